stream_tx_scheduler: RTL and testbench

- Transmit-side packet scheduler for the GTX stream link; produces the framing that the link receive interface decodes.
- Arbitrates round-robin among NUM_REQ sources, then emits a packet on the shared 32-bit TX path: K28.2 header, payload read from the granted source, XOR checksum trailer.
- Drives K28.5 idle words between packets and enforces a minimum inter-packet gap.

---
 rtl/stream_tx_scheduler_if.sv | 26 ++
 rtl/stream_tx_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_stream_tx_scheduler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_tx_scheduler_if.sv
// Request/read/transmit bundle between the packet sources and the TX scheduler.
// The scheduler takes the slave view; sources and link monitors take the master view.
interface stream_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    Req;
    logic [NUM_REQ*12-1:0] ReqLength;
    logic [NUM_REQ*12-1:0] ReqAddress;
    logic [NUM_REQ*32-1:0] SrcData;
    logic [NUM_REQ-1:0]    Grant;
    logic [NUM_REQ-1:0]    RdEn;
    logic [31:0]           TxData;
    logic                  TxCharIsK;
    logic                  Busy;
    logic [15:0]           PacketCount;

    modport master (
        output Req, ReqLength, ReqAddress, SrcData,
        input  Grant, RdEn, TxData, TxCharIsK, Busy, PacketCount
    );

    modport slave (
        input  Req, ReqLength, ReqAddress, SrcData,
        output Grant, RdEn, TxData, TxCharIsK, Busy, PacketCount
    );
endinterface

// File: rtl/stream_tx_scheduler.sv
// Round-robin TX packet scheduler: K28.2 header, payload from the granted source,
// XOR checksum trailer, then a minimum run of K28.5 idle words before the next grant.
module stream_tx_scheduler #(
    parameter int         NUM_REQ     = 4,
    parameter logic [7:0] KSTART      = 8'h5C,
    parameter logic [7:0] KIDLE       = 8'hBC,
    parameter int         IDLE_GAP    = 2,
    parameter int         MAX_PAYLOAD = 4093
) (
    input logic                Clock,
    input logic                Reset,
    stream_tx_scheduler_if.slave bus
);
    localparam int          PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [11:0] MAX_LEN   = 12'(MAX_PAYLOAD);
    localparam logic [11:0] GAP_LOAD  = 12'(IDLE_GAP - 1);
    localparam logic [31:0] IDLE_WORD = {24'h000000, KIDLE};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_TRL  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [NUM_REQ-1:0]  grant_r, grant_s, rden_r, rden_s, onehot_s;
    logic [31:0]         tx_data_r, tx_data_s, csum_r, csum_s, src_word_s;
    logic                tx_k_r, tx_k_s, busy_r, busy_s, found_s;
    logic [15:0]         pkt_cnt_r, pkt_cnt_s;
    logic [PW-1:0]       ptr_r, ptr_s, gidx_r, gidx_s, win_s;
    logic [11:0]         pc_r, pc_s, addr_r, addr_s, win_pc_s;
    logic [11:0]         rd_cnt_r, rd_cnt_s, word_cnt_r, word_cnt_s, gap_cnt_r, gap_cnt_s;
    logic [11:0]         len_a [NUM_REQ];
    logic [11:0]         adr_a [NUM_REQ];
    logic [31:0]         dat_a [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign len_a[gi] = bus.ReqLength[12*gi+11 -: 12];
        assign adr_a[gi] = bus.ReqAddress[12*gi+11 -: 12];
        assign dat_a[gi] = bus.SrcData[32*gi+31 -: 32];
    end

    // Cyclic first-hit search starting at the round-robin pointer.
    always_comb begin
        logic [PW-1:0] idx_v;
        logic          hit_v;
        found_s = 1'b0;
        win_s   = {PW{1'b0}};
        idx_v   = {PW{1'b0}};
        hit_v   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v   = PW'((int'(ptr_r) + i) % NUM_REQ);
            hit_v   = ~found_s & bus.Req[idx_v];
            win_s   = hit_v ? idx_v : win_s;
            found_s = found_s | hit_v;
        end
        win_pc_s   = (len_a[win_s] > MAX_LEN) ? MAX_LEN : len_a[win_s];
        onehot_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
        src_word_s = dat_a[gidx_r];
    end

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        rden_s     = rden_r;
        tx_data_s  = tx_data_r;
        tx_k_s     = tx_k_r;
        busy_s     = busy_r;
        pkt_cnt_s  = pkt_cnt_r;
        ptr_s      = ptr_r;
        gidx_s     = gidx_r;
        pc_s       = pc_r;
        addr_s     = addr_r;
        csum_s     = csum_r;
        rd_cnt_s   = rd_cnt_r;
        word_cnt_s = word_cnt_r;
        gap_cnt_s  = gap_cnt_r;

        // Read strobes run one cycle ahead of the payload on their own count.
        if (rden_r != {NUM_REQ{1'b0}} && rd_cnt_r == pc_r) begin
            rden_s = {NUM_REQ{1'b0}};
        end else if (rden_r != {NUM_REQ{1'b0}}) begin
            rd_cnt_s = rd_cnt_r + 12'd1;
        end else begin
            rd_cnt_s = rd_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                tx_data_s = IDLE_WORD;
                tx_k_s    = 1'b1;
                grant_s   = {NUM_REQ{1'b0}};
                rden_s    = {NUM_REQ{1'b0}};
                busy_s    = 1'b0;
                if (found_s) begin
                    grant_s  = onehot_s;
                    rden_s   = (win_pc_s != 12'd0) ? onehot_s : {NUM_REQ{1'b0}};
                    rd_cnt_s = 12'd1;
                    busy_s   = 1'b1;
                    ptr_s    = PW'((int'(win_s) + 1) % NUM_REQ);
                    gidx_s   = win_s;
                    pc_s     = win_pc_s;
                    addr_s   = adr_a[win_s];
                    csum_s   = 32'h0000_0000;
                    state_s  = ST_HDR;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_HDR: begin
                tx_data_s  = {pc_r + 12'd2, addr_r, KSTART};
                tx_k_s     = 1'b1;
                word_cnt_s = 12'd0;
                state_s    = (pc_r == 12'd0) ? ST_TRL : ST_DATA;
            end
            ST_DATA: begin
                tx_data_s  = src_word_s;
                tx_k_s     = 1'b0;
                csum_s     = csum_r ^ src_word_s;
                word_cnt_s = word_cnt_r + 12'd1;
                state_s    = (word_cnt_r == pc_r - 12'd1) ? ST_TRL : ST_DATA;
            end
            ST_TRL: begin
                tx_data_s = csum_r;
                tx_k_s    = 1'b0;
                pkt_cnt_s = pkt_cnt_r + 16'd1;
                gap_cnt_s = GAP_LOAD;
                state_s   = (IDLE_GAP <= 1) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                tx_data_s = IDLE_WORD;
                tx_k_s    = 1'b1;
                grant_s   = {NUM_REQ{1'b0}};
                busy_s    = 1'b0;
                if (gap_cnt_r <= 12'd1) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - 12'd1;
                    state_s   = ST_GAP;
                end
            end
            default: begin
                tx_data_s = IDLE_WORD;
                tx_k_s    = 1'b1;
                grant_s   = {NUM_REQ{1'b0}};
                rden_s    = {NUM_REQ{1'b0}};
                busy_s    = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Output and datapath registers; reset truncates any packet in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            grant_r    <= {NUM_REQ{1'b0}};
            rden_r     <= {NUM_REQ{1'b0}};
            tx_data_r  <= IDLE_WORD;
            tx_k_r     <= 1'b1;
            busy_r     <= 1'b0;
            pkt_cnt_r  <= 16'd0;
            ptr_r      <= {PW{1'b0}};
            gidx_r     <= {PW{1'b0}};
            pc_r       <= 12'd0;
            addr_r     <= 12'd0;
            csum_r     <= 32'h0000_0000;
            rd_cnt_r   <= 12'd0;
            word_cnt_r <= 12'd0;
            gap_cnt_r  <= 12'd0;
        end else begin
            grant_r    <= grant_s;
            rden_r     <= rden_s;
            tx_data_r  <= tx_data_s;
            tx_k_r     <= tx_k_s;
            busy_r     <= busy_s;
            pkt_cnt_r  <= pkt_cnt_s;
            ptr_r      <= ptr_s;
            gidx_r     <= gidx_s;
            pc_r       <= pc_s;
            addr_r     <= addr_s;
            csum_r     <= csum_s;
            rd_cnt_r   <= rd_cnt_s;
            word_cnt_r <= word_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
        end
    end

    assign bus.Grant       = grant_r;
    assign bus.RdEn        = rden_r;
    assign bus.TxData      = tx_data_r;
    assign bus.TxCharIsK   = tx_k_r;
    assign bus.Busy        = busy_r;
    assign bus.PacketCount = pkt_cnt_r;
endmodule

// File: tb/tb_stream_tx_scheduler.sv
// Directed bench for stream_tx_scheduler: framing, round-robin order, gap,
// zero/clamped lengths, mid-packet reset and false-start immunity.
module tb_stream_tx_scheduler;
    localparam int N = 4;

    logic        Clock = 1'b0;
    logic        Reset;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [N][8];
    logic [11:0] rd_ptr [N];
    logic [31:0] src_data [N];

    stream_tx_scheduler_if #(.NUM_REQ(N)) bus ();
    stream_tx_scheduler #(.NUM_REQ(N)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    always #5 Clock = ~Clock;

    assign bus.SrcData = {src_data[3], src_data[2], src_data[1], src_data[0]};

    function automatic logic [31:0] src_word(input int i, input logic [11:0] p);
        logic [2:0] lo;
        lo = p[2:0];
        if (p < 12'd8) return mem[i][lo];
        return {8'hC0, 4'(i), 8'h00, p};
    endfunction

    // Source model: word returned the cycle after its read strobe, restart per grant.
    always @(posedge Clock) begin
        for (int i = 0; i < N; i++) begin
            if (!bus.Grant[i]) begin
                rd_ptr[i] <= 12'd0;
            end else if (bus.RdEn[i]) begin
                src_data[i] <= src_word(i, rd_ptr[i]);
                rd_ptr[i]   <= rd_ptr[i] + 12'd1;
            end
        end
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [11:0] len, input logic [11:0] addr);
        bus.Req[i]               = 1'b1;
        bus.ReqLength[12*i +: 12]  = len;
        bus.ReqAddress[12*i +: 12] = addr;
    endtask

    task automatic do_reset;
        Reset   = 1'b1;
        bus.Req = 4'b0000;
        tick;
        tick;
        Reset   = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, 64'(bus.TxData), 64'h0000_00BC);
        check({tag, "_k"}, 64'(bus.TxCharIsK), 64'd1);
    endtask

    initial begin
        int sop;
        int rd;
        int bad;
        logic [31:0] exp_x;
        logic [31:0] w;

        Reset          = 1'b1;
        bus.Req        = 4'b0000;
        bus.ReqLength  = 48'h0;
        bus.ReqAddress = 48'h0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++)
                mem[i][k] = 32'h0;

        // Reset state
        tick;
        tick;
        check("rst_grant", 64'(bus.Grant), 64'h0);
        check("rst_rden", 64'(bus.RdEn), 64'h0);
        check_idle("rst");
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_pcnt", 64'(bus.PacketCount), 64'd0);
        Reset = 1'b0;
        tick;

        // Single request, P=3
        mem[1][0] = 32'hAAAA_0001;
        mem[1][1] = 32'hBBBB_0002;
        mem[1][2] = 32'hCCCC_0003;
        set_req(1, 12'd3, 12'h040);
        tick;
        bus.Req = 4'b0000;
        check("s_grant", 64'(bus.Grant), 64'h2);
        check("s_rden0", 64'(bus.RdEn), 64'h2);
        check("s_busy", 64'(bus.Busy), 64'd1);
        check_idle("s_g");
        tick;
        check("s_hdr", 64'(bus.TxData), 64'h0050_405C);
        check("s_hdr_k", 64'(bus.TxCharIsK), 64'd1);
        check("s_rden1", 64'(bus.RdEn), 64'h2);
        tick;
        check("s_a", 64'(bus.TxData), 64'hAAAA_0001);
        check("s_a_k", 64'(bus.TxCharIsK), 64'd0);
        check("s_rden2", 64'(bus.RdEn), 64'h2);
        tick;
        check("s_b", 64'(bus.TxData), 64'hBBBB_0002);
        check("s_rden3", 64'(bus.RdEn), 64'h0);
        tick;
        check("s_c", 64'(bus.TxData), 64'hCCCC_0003);
        tick;
        check("s_trl", 64'(bus.TxData), 64'hDDDD_0000);
        check("s_trl_k", 64'(bus.TxCharIsK), 64'd0);
        check("s_pcnt", 64'(bus.PacketCount), 64'd1);
        check("s_grant_trl", 64'(bus.Grant), 64'h2);
        tick;
        check_idle("s_after");
        check("s_grant_off", 64'(bus.Grant), 64'h0);
        check("s_busy_off", 64'(bus.Busy), 64'd0);

        // Round robin, all requesting, P=2
        do_reset;
        for (int i = 0; i < N; i++) begin
            mem[i][0] = 32'hA000_0000 | 32'(i);
            mem[i][1] = 32'h0B00_0000 | (32'(i) << 8);
            set_req(i, 12'd2, 12'h100 + 12'(i));
        end
        tick;
        for (int p = 0; p < 5; p++) begin
            int g;
            g = p % 4;
            check("rr_grant", 64'(bus.Grant), 64'(4'b0001 << g));
            tick;
            check("rr_hdr", 64'(bus.TxData), 64'({12'h004, 12'h100 + 12'(g), 8'h5C}));
            tick;
            check("rr_d0", 64'(bus.TxData), 64'(mem[g][0]));
            tick;
            check("rr_d1", 64'(bus.TxData), 64'(mem[g][1]));
            tick;
            check("rr_trl", 64'(bus.TxData), 64'(mem[g][0] ^ mem[g][1]));
            tick;
            check_idle("rr_gap1");
            check("rr_gap_grant", 64'(bus.Grant), 64'h0);
            tick;
            check_idle("rr_gap2");
        end

        // Zero-length packet
        do_reset;
        set_req(3, 12'd0, 12'h123);
        tick;
        bus.Req = 4'b0000;
        check("z_grant", 64'(bus.Grant), 64'h8);
        check("z_rden0", 64'(bus.RdEn), 64'h0);
        tick;
        check("z_hdr", 64'(bus.TxData), 64'h0021_235C);
        check("z_rden1", 64'(bus.RdEn), 64'h0);
        tick;
        check("z_trl", 64'(bus.TxData), 64'h0);
        check("z_trl_k", 64'(bus.TxCharIsK), 64'd0);
        check("z_rden2", 64'(bus.RdEn), 64'h0);
        check("z_pcnt", 64'(bus.PacketCount), 64'd1);
        tick;
        check("z_grant_off", 64'(bus.Grant), 64'h0);

        // Reset in the middle of a P=10 packet
        do_reset;
        set_req(0, 12'd10, 12'h055);
        tick;
        bus.Req = 4'b0000;
        repeat (4) tick;
        check("r_mid_rden", 64'(bus.RdEn), 64'h1);
        check("r_mid_k", 64'(bus.TxCharIsK), 64'd0);
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        check_idle("r_after");
        check("r_grant", 64'(bus.Grant), 64'h0);
        check("r_rden", 64'(bus.RdEn), 64'h0);
        check("r_pcnt", 64'(bus.PacketCount), 64'd0);
        mem[2][0] = 32'h2222_0000;
        set_req(2, 12'd1, 12'h200);
        tick;
        bus.Req = 4'b0000;
        check("r_regrant", 64'(bus.Grant), 64'h4);
        repeat (3) tick;
        check("r_trl", 64'(bus.TxData), 64'h2222_0000);
        check("r_pcnt2", 64'(bus.PacketCount), 64'd1);

        // Payload word that looks like a start character
        do_reset;
        mem[1][0] = 32'h1234_565C;
        mem[1][1] = 32'h0000_005C;
        set_req(1, 12'd2, 12'h0AB);
        sop = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            bus.Req = 4'b0000;
            if (bus.TxCharIsK && bus.TxData[7:0] == 8'h5C) sop++;
            if (c == 2) begin
                check("k_word", 64'(bus.TxData), 64'h1234_565C);
                check("k_flag", 64'(bus.TxCharIsK), 64'd0);
            end
        end
        check("k_sop", 64'(sop), 64'd1);

        // Length clamp: 12'hFFF requested, 4093 sent
        do_reset;
        for (int k = 0; k < 8; k++) mem[0][k] = 32'h5A00_0000 + 32'(k * 3);
        set_req(0, 12'hFFF, 12'h7AB);
        tick;
        bus.Req = 4'b0000;
        rd    = 0;
        bad   = 0;
        exp_x = 32'h0;
        for (int c = 0; c <= 4096; c++) begin
            if (bus.RdEn[0]) rd++;
            if (c == 1) check("l_hdr", 64'(bus.TxData), 64'hFFF7_AB5C);
            if (c >= 2 && c < 4095) begin
                w = src_word(0, 12'(c - 2));
                exp_x = exp_x ^ w;
                if (bus.TxData !== w || bus.TxCharIsK !== 1'b0) bad++;
            end
            if (c == 4095) begin
                check("l_trl", 64'(bus.TxData), 64'(exp_x));
                check("l_busy", 64'(bus.Busy), 64'd1);
            end
            if (c == 4096) check("l_grant_off", 64'(bus.Grant), 64'h0);
            tick;
        end
        check("l_rden_cnt", 64'(rd), 64'd4093);
        check("l_payload_bad", 64'(bad), 64'd0);
        check("l_pcnt", 64'(bus.PacketCount), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
